// File: rtl/cla_chain_seq.sv
// Multi-precision add/subtract sequencer.
// A single 9-bit carry-lookahead slice is reused once per cycle, least-significant slice first.
// The slice carry is held in a register between cycles.
// Subtraction is done as a + ~b + 1: the inverted B operand and an initial carry of 1 are latched at start.

// 9-bit carry-lookahead adder slice: every carry is expanded directly from generate/propagate terms.
module cla_adder9 (
    input  logic [8:0] a,
    input  logic [8:0] b,
    input  logic       cin,
    output logic [8:0] sum,
    output logic       cout
);
    logic [8:0] g;
    logic [8:0] p;
    logic [9:0] c;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin : lookahead
        logic acc;
        logic prop;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 9; i++) begin
            acc  = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prop & g[j]);
                prop = prop & p[j];
            end
            acc      = acc | (prop & cin);
            c[i + 1] = acc;
        end
        sum  = p ^ c[8:0];
        cout = c[9];
    end
endmodule

module cla_chain_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [9*WORDS-1:0]   a,
    input  logic [9*WORDS-1:0]   b,
    output logic                 busy,
    output logic                 done,
    output logic [9*WORDS-1:0]   result,
    output logic                 cout,
    output logic                 ovf
);
    localparam int N  = 9 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q,  state_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic          carry_q,  carry_d;
    logic [N-1:0]  opa_q,    opa_d;
    logic [N-1:0]  opb_q,    opb_d;
    logic [N-1:0]  result_q, result_d;
    logic          cout_q,   cout_d;
    logic          ovf_q,    ovf_d;

    logic [8:0]    sl_a;
    logic [8:0]    sl_b;
    logic [8:0]    sl_sum;
    logic          sl_cout;

    // Select the operand slice addressed by the current index
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) begin
                sl_a = opa_q[i*9 +: 9];
                sl_b = opb_q[i*9 +: 9];
            end
        end
    end

    cla_adder9 u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    // Next-state and datapath update: accept in IDLE/DONE, one slice per cycle in RUN
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    opa_d   = a;
                    opb_d   = b ^ {N{sub}};
                    carry_d = sub;
                    idx_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                for (int i = 0; i < WORDS; i++) begin
                    if (idx_q == IW'(i)) begin
                        result_d[i*9 +: 9] = sl_sum;
                    end
                end
                carry_d = sl_cout;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    cout_d  = sl_cout;
                    // Signed overflow: the top slice's operands agree in sign but the sum's sign differs
                    ovf_d   = (sl_a[8] == sl_b[8]) && (sl_sum[8] != sl_a[8]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset discards any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
endmodule

// File: tb/tb_cla_chain_seq.sv
// Testbench for cla_chain_seq (WORDS = 4, 36-bit operands).
// The expected outcome of each operation is queued when the operation is issued.
// It is popped and compared when the DUT raises done.
module tb_cla_chain_seq;
    localparam int WORDS = 4;
    localparam int N     = 9 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [N-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    cla_chain_seq #(.WORDS(WORDS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Full-width reference arithmetic for randomized operations
    function automatic exp_t model(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic is);
        logic [N:0]   full;
        logic [N-1:0] bx;
        exp_t         e;
        bx     = is ? ~ib : ib;
        full   = {1'b0, ia} + {1'b0, bx} + {{N{1'b0}}, is};
        e.res  = full[N-1:0];
        e.co   = full[N];
        e.ov   = (ia[N-1] == bx[N-1]) && (full[N-1] != ia[N-1]);
        return e;
    endfunction

    // Drive one start cycle and queue the expected outcome
    task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic is,
                         input logic [N-1:0] er, input logic eco, input logic eov);
        exp_t e;
        e.res = er;
        e.co  = eco;
        e.ov  = eov;
        @(negedge clk);
        a = ia; b = ib; sub = is; start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Step one clock at a time until done, counting cycles and busy samples
    task automatic wait_done(output int cyc, output int bcnt, output bit seen);
        cyc = 0; bcnt = 0; seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (busy) bcnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, cout, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%h cout=%b ovf=%b expected all 0",
                     busy, done, result, cout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [N-1:0] va [2] = '{36'h0000001FF, 36'hFFFFFFFFF};
        logic [N-1:0] vb [2] = '{36'h000000001, 36'h000000001};
        logic [N-1:0] vr [2] = '{36'h000000200, 36'h000000000};
        logic         vc [2] = '{1'b0, 1'b1};
        int cyc, bcnt; bit seen; exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue(va[i], vb[i], 1'b0, vr[i], vc[i], 1'b0);
            wait_done(cyc, bcnt, seen);
            checks++;
            if (!seen || sb.size() == 0) begin
                failures++;
                $display("FAIL add_done_timeout[%0d]: done=%b expected 1", i, done);
            end else begin
                e = sb.pop_front();
                checks++;
                if (result !== e.res || cout !== e.co || ovf !== e.ov) begin
                    failures++;
                    $display("FAIL add[%0d]: result=%h cout=%b ovf=%b expected %h %b %b",
                             i, result, cout, ovf, e.res, e.co, e.ov);
                end
                checks++;
                if (cyc != WORDS || bcnt != WORDS) begin
                    failures++;
                    $display("FAIL add_latency[%0d]: done_after=%0d busy_cycles=%0d expected %0d %0d",
                             i, cyc, bcnt, WORDS, WORDS);
                end
            end
        end
    endtask

    task automatic test_sub();
        logic [N-1:0] va [2] = '{36'h000000005, 36'h000000007};
        logic [N-1:0] vb [2] = '{36'h000000007, 36'h000000005};
        logic [N-1:0] vr [2] = '{36'hFFFFFFFFE, 36'h000000002};
        logic         vc [2] = '{1'b0, 1'b1};
        int cyc, bcnt; bit seen; exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue(va[i], vb[i], 1'b1, vr[i], vc[i], 1'b0);
            wait_done(cyc, bcnt, seen);
            checks++;
            if (!seen || sb.size() == 0) begin
                failures++;
                $display("FAIL sub_done_timeout[%0d]: done=%b expected 1", i, done);
            end else begin
                e = sb.pop_front();
                checks++;
                if (result !== e.res || cout !== e.co || ovf !== e.ov) begin
                    failures++;
                    $display("FAIL sub[%0d]: result=%h cout=%b ovf=%b expected %h %b %b",
                             i, result, cout, ovf, e.res, e.co, e.ov);
                end
            end
        end
    endtask

    task automatic test_ovf();
        logic [N-1:0] va [2] = '{36'h7FFFFFFFF, 36'h800000000};
        logic [N-1:0] vb [2] = '{36'h000000001, 36'h000000001};
        logic         vs [2] = '{1'b0, 1'b1};
        logic [N-1:0] vr [2] = '{36'h800000000, 36'h7FFFFFFFF};
        logic         vc [2] = '{1'b0, 1'b1};
        int cyc, bcnt; bit seen; exp_t e;
        for (int i = 0; i < 2; i++) begin
            issue(va[i], vb[i], vs[i], vr[i], vc[i], 1'b1);
            wait_done(cyc, bcnt, seen);
            checks++;
            if (!seen || sb.size() == 0) begin
                failures++;
                $display("FAIL ovf_done_timeout[%0d]: done=%b expected 1", i, done);
            end else begin
                e = sb.pop_front();
                checks++;
                if (result !== e.res || cout !== e.co || ovf !== e.ov) begin
                    failures++;
                    $display("FAIL ovf[%0d]: result=%h cout=%b ovf=%b expected %h %b %b",
                             i, result, cout, ovf, e.res, e.co, e.ov);
                end
            end
        end
    endtask

    // Starts pulsed while busy must not disturb the latched operands
    task automatic test_busy_ignore();
        int cyc, bcnt; bit seen; exp_t e;
        issue(36'h123456789, 36'h111111111, 1'b0, 36'h23456789A, 1'b0, 1'b0);
        checks++;
        if (cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL flags_clear_on_accept: cout=%b ovf=%b expected 0 0", cout, ovf);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1; a = 36'hABCDEF012; b = 36'h0F0F0F0F0; sub = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(cyc, bcnt, seen);
        checks++;
        if (!seen || sb.size() == 0) begin
            failures++;
            $display("FAIL ignore_done_timeout: done=%b expected 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res || cout !== e.co || ovf !== e.ov) begin
                failures++;
                $display("FAIL ignore_start: result=%h cout=%b ovf=%b expected %h %b %b",
                         result, cout, ovf, e.res, e.co, e.ov);
            end
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL return_idle: busy=%b done=%b expected 0 0", busy, done);
            end
        end
    endtask

    // Start held high: the second operation is accepted in the DONE cycle
    task automatic test_back_to_back();
        int cyc, bcnt; bit seen; exp_t e;
        issue(36'h0000001FF, 36'h000000001, 1'b0, 36'h000000200, 1'b0, 1'b0);
        start = 1'b1;
        a = 36'h000000010; b = 36'h000000003; sub = 1'b1;
        sb.push_back(model(36'h000000010, 36'h000000003, 1'b1));
        wait_done(cyc, bcnt, seen);
        checks++;
        if (!seen || sb.size() == 0) begin
            failures++;
            $display("FAIL b2b_first_timeout: done=%b expected 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res || cout !== e.co || cyc != WORDS) begin
                failures++;
                $display("FAIL b2b_first: result=%h cout=%b after=%0d expected %h %b %0d",
                         result, cout, cyc, e.res, e.co, WORDS);
            end
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", busy, done);
        end
        wait_done(cyc, bcnt, seen);
        checks++;
        if (!seen || sb.size() == 0) begin
            failures++;
            $display("FAIL b2b_second_timeout: done=%b expected 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res || cout !== e.co || ovf !== e.ov || cyc != WORDS) begin
                failures++;
                $display("FAIL b2b_second: result=%h cout=%b ovf=%b after=%0d expected %h %b %b %0d",
                         result, cout, ovf, cyc, e.res, e.co, e.ov, WORDS);
            end
        end
    endtask

    task automatic test_random();
        int cyc, bcnt; bit seen; exp_t e;
        logic [N-1:0] ra, rb; logic rs;
        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            e  = model(ra, rb, rs);
            issue(ra, rb, rs, e.res, e.co, e.ov);
            wait_done(cyc, bcnt, seen);
            checks++;
            if (!seen || sb.size() == 0) begin
                failures++;
                $display("FAIL rand_timeout[%0d]: done=%b expected 1", i, done);
            end else begin
                e = sb.pop_front();
                checks++;
                if (result !== e.res || cout !== e.co || ovf !== e.ov) begin
                    failures++;
                    $display("FAIL rand[%0d]: a=%h b=%h sub=%b result=%h cout=%b ovf=%b expected %h %b %b",
                             i, ra, rb, rs, result, cout, ovf, e.res, e.co, e.ov);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        int cyc, bcnt; bit seen; int dones; exp_t e;
        issue(36'h000000003, 36'h000000004, 1'b0, 36'h000000007, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if ({busy, done, result, cout, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_midop: busy=%b done=%b result=%h cout=%b ovf=%b expected all 0",
                     busy, done, result, cout, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL no_done_after_reset: active_cycles=%0d expected 0", dones);
        end
        issue(36'h0000001FF, 36'h000000001, 1'b0, 36'h000000200, 1'b0, 1'b0);
        wait_done(cyc, bcnt, seen);
        checks++;
        if (!seen || sb.size() == 0) begin
            failures++;
            $display("FAIL post_reset_timeout: done=%b expected 1", done);
        end else begin
            e = sb.pop_front();
            checks++;
            if (result !== e.res || cout !== e.co || ovf !== e.ov || cyc != WORDS) begin
                failures++;
                $display("FAIL post_reset: result=%h cout=%b ovf=%b after=%0d expected %h %b %b %0d",
                         result, cout, ovf, cyc, e.res, e.co, e.ov, WORDS);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ovf();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/cla_chain_seq.md
Name: cla_chain_seq

Overview:
- Multi-cycle, multi-precision add/subtract sequencer built around one instance of the team's 9-bit carry-lookahead adder (CLA_Adder).
- Processes a WORDS x 9-bit operand pair one 9-bit slice per cycle, least-significant slice first.
- Carries the adder's carry-out between slices in a register.
- Sits in the ALU as the wide-arithmetic path, so one CLA slice serves operands wider than 9 bits.

Parameters:
- WORDS, 4, number of 9-bit slices; operand width N = 9*WORDS (36 by default); legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when not busy (state IDLE or DONE).
- sub  input  1  0 = a+b, 1 = a-b; captured with start.
- a  input  N  operand A; captured with start.
- b  input  N  operand B; captured with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- result  output  N  sum/difference.
- cout  output  1  final carry-out; for subtract, 1 = no borrow (a >= b unsigned).
- ovf  output  1  two's-complement signed overflow of the N-bit operation.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is asynchronous and active-high.
- On reset, at any time and including mid-operation:
  - state = IDLE, slice index = 0, carry register = 0.
  - busy, done, result, cout and ovf all = 0.
  - Any operation in flight is discarded.
- State IDLE:
  - busy = 0, done = 0.
  - start = 1 at edge E0:
    - latch a into opa.
    - latch b XOR {N{sub}} into opb.
    - carry register = sub.
    - index = 0.
    - state -> RUN.
- State RUN, one slice per cycle:
  - Adder inputs: opa[9i+8:9i], opb[9i+8:9i], cin = carry register.
  - At each edge:
    - result[9i+8:9i] <= sum.
    - carry <= adder cout.
    - index++.
  - The edge that captures slice WORDS-1 (edge E_WORDS) moves state -> DONE.
  - At that edge, cout <= adder cout and ovf <= (opa_msb == opb_msb) && (sum_msb != opa_msb), using slice WORDS-1 bit 8.
- State DONE:
  - done = 1 and busy = 0 for exactly one cycle.
  - Next edge: state -> IDLE, unless start = 1, which is accepted exactly as in IDLE (back-to-back operation, state -> RUN).
- Latency: done is high in the cycle after edge E_WORDS, i.e. WORDS edges after the accepting edge. Throughput is one operation per WORDS+1 cycles.
- start while busy = 1 is ignored; latched operands and sub are unaffected.
- Changes on a, b or sub after acceptance have no effect.
- result:
  - Valid from the done cycle until the next accepted start.
  - Slices update progressively during RUN, with no guarantee of meaning while busy.
- cout and ovf hold until the next accepted start. At acceptance they clear to 0.
- done, busy and the state are registered outputs; there is no combinational path from start to any output.
- WORDS = 1 degenerates to a single-cycle RUN; behaviour is otherwise identical.

Test Plan:
- Cross-slice carry (WORDS=4): a=0x0000001FF, b=0x000000001, sub=0
  -> result=0x000000200, cout=0, ovf=0.
  - done exactly 4 edges after the accepting edge.
  - busy high for 4 cycles.
- Full ripple: a=0xFFFFFFFFF, b=0x000000001, add
  -> result=0x000000000, cout=1, ovf=0.
- Subtract with borrow: a=0x000000005, b=0x000000007, sub=1
  -> result=0xFFFFFFFFE, cout=0, ovf=0.
  - Then a=7, b=5 -> result=0x000000002, cout=1.
- Signed overflow: a=0x7FFFFFFFF, b=0x000000001, add
  -> result=0x800000000, ovf=1, cout=0.
  - a=0x800000000 minus b=0x000000001 -> result=0x7FFFFFFFF, ovf=1, cout=1.
- Protocol:
  - start pulses while busy with different a/b change nothing: first result is unchanged.
  - start held high through done -> second op accepted in the DONE cycle, with no IDLE cycle between ops.
- Reset mid-op: assert rst asynchronously (between edges) during the 2nd RUN cycle
  -> all outputs 0 immediately.
  - No done pulse follows.
  - A subsequent start completes normally with correct result.
